nr_solver_ctrl: RTL and testbench

NR_SOLVER_CTRL -- requirements
Module: nr_solver_ctrl

---
 rtl/nr_pkg.sv | 43 ++++
 rtl/nr_solver_ctrl_if.sv | 22 ++
 rtl/nr_mac_seq.sv | 78 +++++++
 rtl/nr_solver_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_nr_solver_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nr_pkg.sv
// Shared definitions for the Newton-Raphson solver controller.
//   - default word, fraction, dimension and iteration-counter widths
//   - solver state enumeration
//   - sat_fn: clamps a wide signed value into a narrower signed range
package nr_pkg;

    localparam int DW_DEF  = 32;
    localparam int FW_DEF  = 24;
    localparam int N_DEF   = 3;
    localparam int ITW_DEF = 4;

    // Working width for saturation; covers 2*DW + clog2(N) for DW <= 64, N <= 8.
    localparam int SAT_W = 160;
    localparam logic [SAT_W-1:0] SAT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_MAC    = 3'd2,
        ST_UPDATE = 3'd3,
        ST_FIN    = 3'd4
    } nr_state_t;

    // Clamp a sign-extended value into the signed range of a dw-bit word.
    // The caller detects saturation by comparing the result with the input.
    function automatic logic signed [SAT_W-1:0] sat_fn(input logic signed [SAT_W-1:0] v,
                                                       input int dw);
        logic signed [SAT_W-1:0] hi_v;
        logic signed [SAT_W-1:0] lo_v;
        logic signed [SAT_W-1:0] res_v;
        hi_v = $signed((SAT_ONE << (dw - 32'd1)) - SAT_ONE);
        lo_v = ~hi_v;
        if (v > hi_v) begin
            res_v = hi_v;
        end else if (v < lo_v) begin
            res_v = lo_v;
        end else begin
            res_v = v;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/nr_solver_ctrl_if.sv
// Function-evaluation bus between the solver (master) and the F / J^-1
// evaluator (slave).
//   eval_req : solver requests F(x) and J^-1(x) for eval_x
//   eval_x   : current iterate, N words
//   eval_ack : evaluator data valid
//   eval_f   : F vector, N words
//   eval_ij  : inverse Jacobian, row-major N*N words
interface nr_solver_ctrl_if
    import nr_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF
);
    logic              eval_req;
    logic [N*DW-1:0]   eval_x;
    logic              eval_ack;
    logic [N*DW-1:0]   eval_f;
    logic [N*N*DW-1:0] eval_ij;

    modport master (output eval_req, eval_x, input eval_ack, eval_f, eval_ij);
    modport slave  (input eval_req, eval_x, output eval_ack, eval_f, eval_ij);
endinterface

// File: rtl/nr_mac_seq.sv
// Sequential row multiply-accumulate: one product per valid cycle, N products
// per row. At the end of each row the accumulator is shifted right by FW
// (floor) and saturated to DW bits.
//   clr      : abandon any partial row, clear accumulator and column
//   vld      : a*b is a valid term this cycle
//   a, b     : signed DW-bit operands
//   row_done : one-cycle pulse, row_res/row_sat valid
//   row_res  : saturated row result
//   row_sat  : row result was clamped
module nr_mac_seq
    import nr_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int FW = FW_DEF,
    parameter int N  = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 vld,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic                 row_done,
    output logic [DW-1:0]        row_res,
    output logic                 row_sat
);
    localparam int AW = 2*DW + $clog2(N);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] COL_LAST = CW'(N-1);

    logic [CW-1:0]          col_r;
    logic signed [AW-1:0]   acc_r;
    logic                   row_done_r;
    logic [DW-1:0]          row_res_r;
    logic                   row_sat_r;
    logic signed [2*DW-1:0] prod_s;
    logic signed [AW-1:0]   acc_next_s;
    logic signed [AW-1:0]   shifted_s;
    logic signed [SAT_W-1:0] ext_s;
    logic signed [SAT_W-1:0] sat_s;

    // Next accumulator value; column 0 starts a fresh row from zero.
    always_comb begin
        prod_s     = a * b;
        acc_next_s = ((col_r == {CW{1'b0}}) ? {AW{1'b0}} : acc_r) + AW'(prod_s);
        shifted_s  = acc_next_s >>> FW;
        ext_s      = SAT_W'(shifted_s);
        sat_s      = sat_fn(ext_s, DW);
    end

    // Accumulator, column counter and registered row result.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col_r      <= {CW{1'b0}};
            acc_r      <= {AW{1'b0}};
            row_done_r <= 1'b0;
            row_res_r  <= {DW{1'b0}};
            row_sat_r  <= 1'b0;
        end else if (vld) begin
            acc_r <= acc_next_s;
            if (col_r == COL_LAST) begin
                col_r      <= {CW{1'b0}};
                row_done_r <= 1'b1;
                row_res_r  <= sat_s[DW-1:0];
                row_sat_r  <= (sat_s != ext_s);
            end else begin
                col_r      <= col_r + {{(CW-1){1'b0}}, 1'b1};
                row_done_r <= 1'b0;
            end
        end else begin
            row_done_r <= 1'b0;
        end
    end

    assign row_done = row_done_r;
    assign row_res  = row_res_r;
    assign row_sat  = row_sat_r;
endmodule

// File: rtl/nr_solver_ctrl.sv
// Newton-Raphson iteration controller: x <- x - J^-1(x) * F(x) in signed
// fixed point, with an external evaluator supplying F and J^-1.
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin a solve (IDLE only) / cancel a solve
//   x0, max_iter,tol: initial vector, iteration limit, convergence tolerance
//   eval_bus        : evaluator request/ack bus (master side)
//   root, done      : solution vector, one-cycle completion pulse
//   converged, ovf  : tolerance met, saturation seen during the solve
//   iter_count, busy: iterations executed, controller not IDLE
module nr_solver_ctrl
    import nr_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int FW  = FW_DEF,
    parameter int N   = N_DEF,
    parameter int ITW = ITW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [N*DW-1:0]        x0,
    input  logic [ITW-1:0]         max_iter,
    input  logic [DW-1:0]          tol,
    nr_solver_ctrl_if.master       eval_bus,
    output logic [N*DW-1:0]        root,
    output logic                   done,
    output logic                   converged,
    output logic                   ovf,
    output logic [ITW-1:0]         iter_count,
    output logic                   busy
);
    localparam int RW = $clog2(N);
    localparam logic [RW-1:0]  IDX_LAST = RW'(N-1);
    localparam logic [ITW-1:0] ITER_ONE = {{(ITW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]  D_MIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]  D_MAX    = ~D_MIN;

    nr_state_t         state_r, state_next_s;
    logic [N*DW-1:0]   x_r, f_r, d_r, root_r;
    logic [N*N*DW-1:0] ij_r;
    logic [ITW-1:0]    max_iter_r, iter_r;
    logic [DW-1:0]     tol_r;
    logic [RW-1:0]     row_r, col_r;
    logic              conv_r, ovf_r, done_r, busy_r, eval_req_r;

    int                mac_idx_s;
    logic [DW-1:0]     mac_a_s, mac_b_s, mac_res_s;
    logic              mac_vld_s, mac_clr_s, mac_done_s, mac_sat_s, mac_last_s;

    logic [N*DW-1:0]   d_cur_s, x_new_s;
    logic [DW-1:0]     d_el_s, x_el_s, abs_s;
    logic signed [SAT_W-1:0] diff_s, dsat_s;
    logic              upd_sat_s, conv_s;

    // Operand selection for the row-major J^-1 * F walk.
    always_comb begin
        mac_idx_s  = 32'(row_r) * N + 32'(col_r);
        mac_a_s    = ij_r[mac_idx_s*DW +: DW];
        mac_b_s    = f_r[32'(col_r)*DW +: DW];
        mac_last_s = (row_r == IDX_LAST) && (col_r == IDX_LAST);
        mac_vld_s  = (state_r == ST_MAC) && !abort;
        mac_clr_s  = (state_r != ST_MAC);
    end

    nr_mac_seq #(.DW(DW), .FW(FW), .N(N)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr_s),
        .vld      (mac_vld_s),
        .a        (mac_a_s),
        .b        (mac_b_s),
        .row_done (mac_done_s),
        .row_res  (mac_res_s),
        .row_sat  (mac_sat_s)
    );

    // Step vector and update: rows shift in at the top so row i ends at
    // word i; the last row arrives during UPDATE and is merged here.
    always_comb begin
        d_cur_s   = {mac_res_s, d_r[N*DW-1:DW]};
        x_new_s   = {(N*DW){1'b0}};
        upd_sat_s = 1'b0;
        conv_s    = 1'b1;
        d_el_s    = {DW{1'b0}};
        x_el_s    = {DW{1'b0}};
        abs_s     = {DW{1'b0}};
        diff_s    = {SAT_W{1'b0}};
        dsat_s    = {SAT_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            d_el_s = d_cur_s[i*DW +: DW];
            x_el_s = x_r[i*DW +: DW];
            diff_s = SAT_W'($signed(x_el_s)) - SAT_W'($signed(d_el_s));
            dsat_s = sat_fn(diff_s, DW);
            x_new_s[i*DW +: DW] = dsat_s[DW-1:0];
            if (dsat_s != diff_s) begin
                upd_sat_s = 1'b1;
            end else begin
                upd_sat_s = upd_sat_s;
            end
            // The most negative step has no positive twin; clamp its magnitude.
            if (d_el_s == D_MIN) begin
                abs_s = D_MAX;
            end else if (d_el_s[DW-1]) begin
                abs_s = -d_el_s;
            end else begin
                abs_s = d_el_s;
            end
            if (abs_s > tol_r) begin
                conv_s = 1'b0;
            end else begin
                conv_s = conv_s;
            end
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    state_next_s = ST_IDLE;
                end else if (max_iter == {ITW{1'b0}}) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (eval_req_r && eval_bus.eval_ack) begin
                    state_next_s = ST_MAC;
                end else begin
                    state_next_s = ST_EVAL;
                end
            end
            ST_MAC: begin
                if (mac_last_s) begin
                    state_next_s = ST_UPDATE;
                end else begin
                    state_next_s = ST_MAC;
                end
            end
            ST_UPDATE: begin
                if (conv_s || ((iter_r + ITER_ONE) == max_iter_r)) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_EVAL;
                end
            end
            ST_FIN:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
        if (abort && (state_r != ST_IDLE)) begin
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r        <= {(N*DW){1'b0}};
            f_r        <= {(N*DW){1'b0}};
            d_r        <= {(N*DW){1'b0}};
            root_r     <= {(N*DW){1'b0}};
            ij_r       <= {(N*N*DW){1'b0}};
            max_iter_r <= {ITW{1'b0}};
            iter_r     <= {ITW{1'b0}};
            tol_r      <= {DW{1'b0}};
            row_r      <= {RW{1'b0}};
            col_r      <= {RW{1'b0}};
            conv_r     <= 1'b0;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            eval_req_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            eval_req_r <= (state_next_s == ST_EVAL);
            busy_r     <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x_r        <= x0;
                        max_iter_r <= max_iter;
                        tol_r      <= tol;
                        iter_r     <= {ITW{1'b0}};
                        conv_r     <= 1'b0;
                        ovf_r      <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    if (eval_req_r && eval_bus.eval_ack && !abort) begin
                        f_r   <= eval_bus.eval_f;
                        ij_r  <= eval_bus.eval_ij;
                        row_r <= {RW{1'b0}};
                        col_r <= {RW{1'b0}};
                    end
                end
                ST_MAC: begin
                    if (!abort) begin
                        if (col_r == IDX_LAST) begin
                            col_r <= {RW{1'b0}};
                            row_r <= row_r + {{(RW-1){1'b0}}, 1'b1};
                        end else begin
                            col_r <= col_r + {{(RW-1){1'b0}}, 1'b1};
                        end
                        if (mac_done_s) begin
                            d_r <= d_cur_s;
                            if (mac_sat_s) begin
                                ovf_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_UPDATE: begin
                    if (!abort) begin
                        x_r    <= x_new_s;
                        iter_r <= iter_r + ITER_ONE;
                        conv_r <= conv_s;
                        if (upd_sat_s || (mac_done_s && mac_sat_s)) begin
                            ovf_r <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    if (!abort) begin
                        root_r <= x_r;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign eval_bus.eval_req = eval_req_r;
    assign eval_bus.eval_x   = x_r;
    assign root              = root_r;
    assign done              = done_r;
    assign converged         = conv_r;
    assign ovf               = ovf_r;
    assign iter_count        = iter_r;
    assign busy              = busy_r;
endmodule

// File: tb/tb_nr_solver_ctrl.sv
// Directed self-checking bench for nr_solver_ctrl at default parameters.
// A behavioural evaluator answers eval_req with F and J^-1 chosen by mode:
//   0: F = x - 2.0, J^-1 = I        1: F_0 = -128.0, others 0, J^-1 = I
//   2: F = x - 2.0, J^-1 = 0.5*I
module tb_nr_solver_ctrl;
    localparam int DW  = 32;
    localparam int FW  = 24;
    localparam int N   = 3;
    localparam int ITW = 4;
    localparam logic [DW-1:0] TOL = 32'h00001000;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [N*DW-1:0]   x0;
    logic [ITW-1:0]    max_iter;
    logic [DW-1:0]     tol;
    logic [N*DW-1:0]   root;
    logic              done;
    logic              converged;
    logic              ovf;
    logic [ITW-1:0]    iter_count;
    logic              busy;

    nr_solver_ctrl_if #(.DW(DW), .N(N)) eval_bus ();

    nr_solver_ctrl #(.DW(DW), .FW(FW), .N(N), .ITW(ITW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .x0         (x0),
        .max_iter   (max_iter),
        .tol        (tol),
        .eval_bus   (eval_bus),
        .root       (root),
        .done       (done),
        .converged  (converged),
        .ovf        (ovf),
        .iter_count (iter_count),
        .busy       (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int resp_mode = 0;
    int ack_dly   = 0;

    // Monitor state, written only by the monitor process.
    int done_cnt = 0;
    int done_cyc = 0;
    int req_cnt  = 0;
    int req_run  = 0;
    int max_run  = 0;
    int xchg     = 0;
    logic            prev_req = 1'b0;
    logic [N*DW-1:0] prev_x   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge.
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (eval_bus.eval_req) begin
            req_cnt = req_cnt + 1;
            req_run = req_run + 1;
            if (req_run > max_run) max_run = req_run;
            if (prev_req && (eval_bus.eval_x != prev_x)) xchg = xchg + 1;
        end else begin
            req_run = 0;
        end
        prev_req = eval_bus.eval_req;
        prev_x   = eval_bus.eval_x;
    end

    // Behavioural evaluator with programmable ack delay.
    initial begin
        logic [N*DW-1:0]   f_v;
        logic [N*N*DW-1:0] ij_v;
        logic [DW-1:0]     diag_v;
        int                wait_v;
        wait_v = 0;
        eval_bus.eval_ack = 1'b0;
        eval_bus.eval_f   = '0;
        eval_bus.eval_ij  = '0;
        forever begin
            @(negedge clk);
            f_v  = '0;
            ij_v = '0;
            if (resp_mode == 1) begin
                f_v[DW-1:0] = 32'h80000000;
            end else begin
                for (int i = 0; i < N; i++)
                    f_v[i*DW +: DW] = eval_bus.eval_x[i*DW +: DW] - 32'h02000000;
            end
            diag_v = (resp_mode == 2) ? 32'h00800000 : 32'h01000000;
            for (int i = 0; i < N; i++) ij_v[(i*N+i)*DW +: DW] = diag_v;
            eval_bus.eval_f  = f_v;
            eval_bus.eval_ij = ij_v;
            if (eval_bus.eval_req && !eval_bus.eval_ack) begin
                if (wait_v >= ack_dly) begin
                    eval_bus.eval_ack = 1'b1;
                    wait_v = 0;
                end else begin
                    wait_v = wait_v + 1;
                end
            end else begin
                eval_bus.eval_ack = 1'b0;
                wait_v = 0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One solve; lat is cycles from the start cycle to the done cycle (-1 if none).
    task automatic run_solve(input int md, input logic [N*DW-1:0] xi, input logic [ITW-1:0] mi,
                             input int dly, input logic glitch, input int abort_at,
                             output int lat, output int ndone, output logic done_after,
                             output logic busy_ab, output logic req_ab);
        int s;
        int d0;
        lat = -1;
        busy_ab = 1'b1;
        req_ab  = 1'b1;
        resp_mode = md;
        ack_dly   = dly;
        x0        = xi;
        max_iter  = mi;
        tol       = TOL;
        @(negedge clk); #1;
        start = 1'b1;
        s  = cyc;
        d0 = done_cnt;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            start = glitch && ((cyc == s + 1) || (cyc == s + 4));
            if (glitch && (cyc == s + 1)) x0 = {N{32'h11111111}};
            abort = (abort_at > 0) && (cyc == s + abort_at);
            if ((abort_at > 0) && (cyc == s + abort_at + 1)) begin
                busy_ab = busy;
                req_ab  = eval_bus.eval_req;
            end
            if ((abort_at > 0) && (cyc == s + abort_at + 15)) break;
            if (done_cnt != d0) begin
                lat = done_cyc - s;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk); #1;
        done_after = done;
        ndone = done_cnt - d0;
    endtask

    initial begin
        int   lat;
        int   nd;
        logic da, bab, rab;
        logic [N*DW-1:0] two_v;
        logic [N*DW-1:0] x29_v;
        logic [N*DW-1:0] xs_v;
        two_v = {N{32'h02000000}};
        x29_v = {32'h00000000, 32'h00000000, 32'h7F000000};
        xs_v  = {32'h00300000, 32'hFFF00000, 32'h01000000};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        x0 = '0; max_iter = '0; tol = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_root", root, 0);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_req", eval_bus.eval_req, 0);
        check_val("rst_iter", iter_count, 0);
        check_val("rst_flags", {converged, ovf}, 0);
        check_val("rst_evalx", eval_bus.eval_x, 0);
        rst = 1'b0;
        @(negedge clk);

        // Two Newton steps from 0 to 2.0.
        run_solve(0, '0, 4'd8, 0, 1'b0, 0, lat, nd, da, bab, rab);
        check_val("t1_lat", lat, 24);
        check_val("t1_root", root, two_v);
        check_val("t1_conv", converged, 1);
        check_val("t1_iter", iter_count, 2);
        check_val("t1_ovf", ovf, 0);
        check_val("t1_done_pulse", da, 0);

        // max_iter = 0 skips evaluation.
        begin
            int r0;
            r0 = req_cnt;
            run_solve(0, xs_v, 4'd0, 0, 1'b0, 0, lat, nd, da, bab, rab);
            check_val("t2_lat", lat, 2);
            check_val("t2_root", root, xs_v);
            check_val("t2_conv", converged, 0);
            check_val("t2_iter", iter_count, 0);
            check_val("t2_no_req", req_cnt - r0, 0);
        end

        // Update saturates positive.
        run_solve(1, x29_v, 4'd1, 0, 1'b0, 0, lat, nd, da, bab, rab);
        check_val("t3_lat", lat, 13);
        check_val("t3_root", root, {32'h00000000, 32'h00000000, 32'h7FFFFFFF});
        check_val("t3_ovf", ovf, 1);
        check_val("t3_conv", converged, 0);
        check_val("t3_iter", iter_count, 1);

        // Ack delayed by five cycles.
        run_solve(0, '0, 4'd8, 5, 1'b0, 0, lat, nd, da, bab, rab);
        check_val("t4_lat", lat, 34);
        check_val("t4_root", root, two_v);
        check_val("t4_req_run", max_run, 6);
        check_val("t4_ovf_cleared", ovf, 0);
        check_val("t4_iter", iter_count, 2);

        // Abort on MAC cycle 4.
        run_solve(0, xs_v, 4'd8, 0, 1'b0, 5, lat, nd, da, bab, rab);
        check_val("t5_busy", bab, 0);
        check_val("t5_req", rab, 0);
        check_val("t5_no_done", nd, 0);
        check_val("t5_root_held", root, two_v);

        // Normal solve after abort.
        run_solve(0, '0, 4'd8, 0, 1'b0, 0, lat, nd, da, bab, rab);
        check_val("t6_lat", lat, 24);
        check_val("t6_root", root, two_v);
        check_val("t6_conv", converged, 1);

        // start pulses while busy are ignored.
        run_solve(0, '0, 4'd8, 0, 1'b1, 0, lat, nd, da, bab, rab);
        check_val("t7_lat", lat, 24);
        check_val("t7_root", root, two_v);
        check_val("t7_conv", converged, 1);
        check_val("t7_iter", iter_count, 2);

        // Half-step Jacobian stops at the iteration limit: 1.0, 1.5, 1.75.
        run_solve(2, '0, 4'd3, 0, 1'b0, 0, lat, nd, da, bab, rab);
        check_val("t8_lat", lat, 35);
        check_val("t8_root", root, {N{32'h01C00000}});
        check_val("t8_conv", converged, 0);
        check_val("t8_iter", iter_count, 3);

        check_val("evalx_stable", xchg, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
